// File: rtl/parking_gate_controller.sv
// Occupancy tracker for a shared entry/exit gate: grants or refuses requests,
// holds the gate open until a car passes or the wait expires, and keeps parked/empty counts.
module parking_gate_controller #(
   parameter int CAPACITY = 4,
   parameter int CNT_W    = 4,
   parameter int TIMEOUT  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enter_req,
   input  logic             exit_req,
   input  logic             car_pass,
   output logic             enter_ack,
   output logic             exit_ack,
   output logic             reject,
   output logic             gate_open,
   output logic [CNT_W-1:0] parked,
   output logic [CNT_W-1:0] empty,
   output logic             full,
   output logic             timeout_evt
);

   // Handshake: a request is a level held by the sensor; ack/reject are single-cycle
   // pulses decoded from the IDLE state in the same cycle the transition is registered.
   typedef enum logic [1:0] {IDLE, ENTER_OPEN, EXIT_OPEN, CLOSE} state_t;

   localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
   localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] parked_q, parked_d, empty_q;
   logic [7:0]       timer_q, timer_d;
   logic [1:0]       div_q;
   logic             gate_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         parked_q <= '0;
         empty_q  <= CAP;
         timer_q  <= '0;
         div_q    <= '0;
         gate_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         parked_q <= parked_d;
         empty_q  <= CAP - parked_d;
         timer_q  <= timer_d;
         div_q    <= div_q + 2'd1;
         gate_q   <= (state_d == ENTER_OPEN) || (state_d == EXIT_OPEN);
      end
   end

   always_comb begin
      state_d     = state_q;
      parked_d    = parked_q;
      timer_d     = timer_q;
      enter_ack   = 1'b0;
      exit_ack    = 1'b0;
      reject      = 1'b0;
      timeout_evt = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            // Refusals are only re-issued on the free-running divider phase 0.
            if (exit_req) begin
               if (parked_q != '0) begin
                  exit_ack = 1'b1;
                  state_d  = EXIT_OPEN;
               end else if (div_q == 2'd0) begin
                  reject = 1'b1;
               end
            end else if (enter_req) begin
               if (parked_q != CAP) begin
                  enter_ack = 1'b1;
                  state_d   = ENTER_OPEN;
               end else if (div_q == 2'd0) begin
                  reject = 1'b1;
               end
            end
         end
         ENTER_OPEN, EXIT_OPEN: begin
            if (car_pass) begin
               if (state_q == ENTER_OPEN)
                  parked_d = (parked_q < CAP) ? parked_q + 1'b1 : parked_q;
               else
                  parked_d = (parked_q != '0) ? parked_q - 1'b1 : parked_q;
               state_d = CLOSE;
            end else if (timer_q == TO_LAST) begin
               timeout_evt = 1'b1;
               state_d     = CLOSE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         CLOSE: begin
            timer_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign gate_open = gate_q;
   assign parked    = parked_q;
   assign empty     = empty_q;
   assign full      = (parked_q == CAP);

endmodule
